// File: rtl/score_display_driver.sv
// Clocked score display stage: converts each hand total to decimal with a sequential double-dabble
// engine and drives 6-bit character codes for the message and hand fields.
module score_display_driver #(
    parameter int N_HANDS   = 2,
    parameter int HAND_W    = 6,
    parameter int DIGITS    = 2,
    parameter int MSG_LEN   = 4,
    parameter int FLASH_DIV = 25_000_000
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_HANDS*HAND_W-1:0]               hands_in,
    input  logic                                    update,
    input  logic                                    blank_lz,
    input  logic [MSG_LEN*6-1:0]                    msg_in,
    input  logic [1:0]                              msg_mode,
    output logic                                    busy,
    output logic                                    done,
    output logic [(MSG_LEN+N_HANDS*DIGITS)*6-1:0]   char_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + HAND_W;
    localparam int IDX_W = (N_HANDS > 1) ? $clog2(N_HANDS) : 1;
    localparam int CNT_W = $clog2(HAND_W + 1);
    localparam int FL_W  = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);
    localparam logic [5:0] BLANK    = 6'h3F;
    localparam logic [5:0] OVF_CHAR = 6'h0E;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} ConvState;

    ConvState                 state, nextState;
    logic [N_HANDS*HAND_W-1:0] snapshot;
    logic [IDX_W-1:0]         handIdx;
    logic [CNT_W-1:0]         shiftCnt;
    logic [SR_W-1:0]          shiftReg, adjusted, shifted;
    logic [HAND_W-1:0]        curHand;
    logic                     curOvf;
    logic [BCD_W-1:0]         staging [N_HANDS];
    logic [N_HANDS-1:0]       stagingOvf;
    logic [BCD_W-1:0]         dispBcd [N_HANDS];
    logic [N_HANDS-1:0]       dispOvf;
    logic                     pending;
    logic                     lastHand, finish, restart;
    logic [MSG_LEN*6-1:0]     msgReg;
    logic [FL_W-1:0]          flashCnt;
    logic                     flashPhase;
    logic                     leading;
    logic [3:0]               nib;
    logic [5:0]               ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (update) nextState = LOAD;
            LOAD:    nextState = SHIFT;
            SHIFT:   if (shiftCnt == CNT_W'(HAND_W - 1)) nextState = WRITE;
            WRITE:   nextState = (!lastHand || restart) ? LOAD : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // A request arriving on the completion edge itself folds into the immediate restart.
    always_comb begin
        busy     = (state != IDLE);
        lastHand = (handIdx == IDX_W'(N_HANDS - 1));
        finish   = (state == WRITE) && lastHand;
        restart  = finish && (pending || update);
    end

    always_comb begin
        curHand  = snapshot[handIdx*HAND_W +: HAND_W];
        adjusted = shiftReg;
        for (int n = 0; n < DIGITS; n++) begin
            if (shiftReg[HAND_W+4*n +: 4] >= 4'd5)
                adjusted[HAND_W+4*n +: 4] = shiftReg[HAND_W+4*n +: 4] + 4'd3;
        end
        shifted = {adjusted[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot   <= '0;
            handIdx    <= '0;
            shiftCnt   <= '0;
            shiftReg   <= '0;
            curOvf     <= 1'b0;
            stagingOvf <= '0;
            dispOvf    <= '0;
            pending    <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < N_HANDS; i++) begin
                staging[i] <= '0;
                dispBcd[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (busy && update && !restart) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (update) begin
                        snapshot <= hands_in;
                        handIdx  <= '0;
                    end
                end
                LOAD: begin
                    shiftReg <= {{BCD_W{1'b0}}, curHand};
                    curOvf   <= (32'(curHand) > MAX_VAL);
                    shiftCnt <= '0;
                end
                SHIFT: begin
                    shiftReg <= shifted;
                    shiftCnt <= shiftCnt + 1'b1;
                end
                WRITE: begin
                    staging[handIdx]    <= shiftReg[SR_W-1 -: BCD_W];
                    stagingOvf[handIdx] <= curOvf;
                    if (lastHand) begin
                        // All hands become visible together, including the one finishing now.
                        for (int i = 0; i < N_HANDS; i++) begin
                            dispBcd[i] <= (i == int'(handIdx)) ? shiftReg[SR_W-1 -: BCD_W] : staging[i];
                            dispOvf[i] <= (i == int'(handIdx)) ? curOvf : stagingOvf[i];
                        end
                        done    <= 1'b1;
                        pending <= 1'b0;
                        if (restart) begin
                            snapshot <= hands_in;
                            handIdx  <= '0;
                        end
                    end else begin
                        handIdx <= handIdx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flash always begins with a visible half-period because the timer idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msgReg     <= {MSG_LEN{BLANK}};
            flashCnt   <= '0;
            flashPhase <= 1'b0;
        end else begin
            if (msg_mode == 2'b01) begin
                if (flashCnt == FL_W'(FLASH_DIV - 1)) begin
                    flashCnt   <= '0;
                    flashPhase <= ~flashPhase;
                end else begin
                    flashCnt <= flashCnt + 1'b1;
                end
            end else begin
                flashCnt   <= '0;
                flashPhase <= 1'b0;
            end
            msgReg <= (msg_mode == 2'b10 || (msg_mode == 2'b01 && flashPhase)) ? {MSG_LEN{BLANK}} : msg_in;
        end
    end

    always_comb begin
        char_out              = '0;
        char_out[MSG_LEN*6-1:0] = msgReg;
        leading = 1'b0;
        nib     = '0;
        ch      = '0;
        for (int i = 0; i < N_HANDS; i++) begin
            leading = 1'b1;
            for (int d = DIGITS - 1; d >= 0; d--) begin
                nib     = dispBcd[i][4*d +: 4];
                leading = leading & (nib == 4'd0);
                if (dispOvf[i])                     ch = OVF_CHAR;
                else if (blank_lz && leading && d != 0) ch = BLANK;
                else                                ch = {2'b00, nib};
                char_out[(MSG_LEN + i*DIGITS + d)*6 +: 6] = ch;
            end
        end
    end

endmodule
